reg8_serial_reader: RTL and testbench
=====================================

Name: reg8_serial_reader

Overview:
- Read-side counterpart of the 8-bit register load control.
- Snapshots the register's parallel Q value (the FF outputs that feed the load mux) on request.
- Shifts the snapshot out one bit at a time with a start/busy/done handshake.
- Lets a downstream consumer read the register serially while the register keeps operating independently.

Parameters:
- WIDTH, 8: register width in bits; legal range >= 2.
- LSB_FIRST, 1: 1 = bit 0 shifted first; 0 = bit WIDTH-1 shifted first.
- CLK_DIV, 1: clock cycles each bit is held on sout; legal range >= 1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a read-out; sampled only in IDLE.
- data_in  input  WIDTH  parallel register Q value (SFF bus).
- sout  output  1  serial data bit.
- sout_valid  output  1  high while sout carries a frame bit.
- bit_strobe  output  1  one-cycle pulse on the first cycle of each new bit.
- busy  output  1  high while a frame is being shifted.
- done  output  1  one-cycle pulse after the last bit period.

Behaviour:
- Reset: rst_n=0 immediately forces state IDLE and clears shadow register, bit counter and divider counter. sout=0, sout_valid=0, bit_strobe=0, busy=0, done=0. Applies asynchronously, including mid-frame. Outputs stay at these values until the first rising clk edge after rst_n returns high.
- FSM states: IDLE, SHIFT, DONE (encoding at implementer's choice). All outputs are registered.
- IDLE:
  - All outputs 0.
  - On an edge with start=1: capture data_in into the shadow shift register, set bit counter=0 and divider=0, go to SHIFT.
  - Cycle after the start edge: busy=1, sout_valid=1, bit_strobe=1, sout = first bit (data_in[0] if LSB_FIRST else data_in[WIDTH-1]).
- SHIFT:
  - Each bit is held exactly CLK_DIV cycles; the divider counts 0..CLK_DIV-1.
  - When the divider wraps and bit counter < WIDTH-1: shift the next bit onto sout, increment bit counter, pulse bit_strobe for 1 cycle.
  - When the divider wraps on bit WIDTH-1: go to DONE.
  - Frame length is exactly WIDTH*CLK_DIV cycles of sout_valid=1.
  - With CLK_DIV=1, bit_strobe stays high for the whole frame.
- DONE: exactly one cycle.
  - done=1, busy=0, sout_valid=0, sout=0.
  - Then unconditional return to IDLE.
- Latency:
  - start edge at cycle k: first bit valid in cycle k+1, last bit ends at cycle k+WIDTH*CLK_DIV, done=1 in cycle k+WIDTH*CLK_DIV+1.
  - Minimum start-to-start spacing is WIDTH*CLK_DIV+2 cycles.
- Snapshot: data_in changes after the capture edge have no effect on the frame in progress.
- start in SHIFT or DONE is ignored; it is not queued. A start held high through DONE is accepted in the following IDLE cycle.
- Bit counter width is clog2(WIDTH); divider width is clog2(CLK_DIV), minimum 1 bit. Neither counter ever exceeds its terminal value.
- No X on any output after reset, for any start/data_in combination.

Test Plan:
- Reset + LSB_FIRST=1, CLK_DIV=1, data_in=8'hA5, start pulse at cycle 0 -> sout sequence 1,0,1,0,0,1,0,1 in cycles 1-8; sout_valid=1 and busy=1 in cycles 1-8; done=1 only in cycle 9; all outputs 0 in cycle 10.
- LSB_FIRST=0, CLK_DIV=3, data_in=8'hC3 -> sout 1,1,0,0,0,0,1,1, each bit held 3 cycles; bit_strobe pulses in cycles 1,4,...,22; done=1 in cycle 25.
- data_in switched from 8'hFF to 8'h00 one cycle after start, with CLK_DIV=1 -> all 8 sout bits = 1.
- start held high continuously, CLK_DIV=1 -> frames begin at cycles 1, 11, 21; no start accepted during SHIFT/DONE; done pulses in cycles 9, 19, 29.
- rst_n driven low asynchronously mid-bit 4 of a frame -> sout, sout_valid, busy, done go 0 without a clk edge. After release, a new start with data_in=8'h01 yields a clean frame 1,0,0,0,0,0,0,0.
- start=0 for 50 cycles after reset -> all outputs remain 0 throughout.

Source files
------------

// File: rtl/reg8_serial_reader.sv
// Snapshots a WIDTH-bit parallel register value on start and shifts it out serially, each bit held CLK_DIV cycles.
// Latency: first bit one cycle after the start edge, done WIDTH*CLK_DIV+1 cycles after it; start is ignored while busy or done.
module reg8_serial_reader #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int CLK_DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             sout,
    output logic             sout_valid,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [DW-1:0]    divcnt_q, divcnt_d;
    logic             sout_q,   sout_d;
    logic             valid_q,  valid_d;
    logic             strobe_q, strobe_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            divcnt_q <= '0;
            sout_q   <= 1'b0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            divcnt_q <= divcnt_d;
            sout_q   <= sout_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The bit on sout always sits at the outgoing end of shreg_q; a shift exposes the next one.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        divcnt_d = divcnt_q;
        sout_d   = 1'b0;
        valid_d  = 1'b0;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d  = data_in;
                    bitcnt_d = '0;
                    divcnt_d = '0;
                    state_d  = ST_SHIFT;
                    sout_d   = (LSB_FIRST != 0) ? data_in[0] : data_in[WIDTH-1];
                    valid_d  = 1'b1;
                    strobe_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (divcnt_q == DIV_LAST) begin
                    divcnt_d = '0;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + BW'(1);
                        if (LSB_FIRST != 0) begin
                            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                            sout_d  = shreg_q[1];
                        end else begin
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                            sout_d  = shreg_q[WIDTH-2];
                        end
                        valid_d  = 1'b1;
                        strobe_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end else begin
                    divcnt_d = divcnt_q + DW'(1);
                    sout_d   = sout_q;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign bit_strobe = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_reg8_serial_reader.sv
// Bench for reg8_serial_reader: two instances (LSB-first/div1 and MSB-first/div3) checked each cycle against a frame-offset model.
module tb_reg8_serial_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] din_a, din_b;
    logic       sout_a, vld_a, stb_a, busy_a, done_a;
    logic       sout_b, vld_b, stb_b, busy_b, done_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    reg8_serial_reader #(.WIDTH(8), .LSB_FIRST(1), .CLK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(din_a),
        .sout(sout_a), .sout_valid(vld_a), .bit_strobe(stb_a), .busy(busy_a), .done(done_a)
    );

    reg8_serial_reader #(.WIDTH(8), .LSB_FIRST(0), .CLK_DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(din_b),
        .sout(sout_b), .sout_valid(vld_b), .bit_strobe(stb_b), .busy(busy_b), .done(done_b)
    );

    // Model: a frame is described only by the snapshot and the cycle offset since the accepting edge.
    int         mw[2] = '{8, 8};
    int         md[2] = '{1, 3};
    int         ml[2] = '{1, 0};
    bit         act[2];
    int         off[2];
    logic [7:0] snap[2];

    function automatic logic get_start(int i);
        return (i == 0) ? start_a : start_b;
    endfunction

    function automatic logic [7:0] get_din(int i);
        return (i == 0) ? din_a : din_b;
    endfunction

    function automatic logic [4:0] outs(int i);
        if (i == 0) return {sout_a, vld_a, stb_a, busy_a, done_a};
        return {sout_b, vld_b, stb_b, busy_b, done_b};
    endfunction

    function automatic logic [4:0] expected(int i);
        int len;
        int idx;
        logic b;
        len = mw[i] * md[i];
        if (!act[i]) return 5'b0;
        if (off[i] <= len) begin
            idx = (off[i] - 1) / md[i];
            b   = (ml[i] != 0) ? snap[i][idx] : snap[i][mw[i] - 1 - idx];
            return {b, 1'b1, ((off[i] - 1) % md[i]) == 0, 1'b1, 1'b0};
        end
        return 5'b00001;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act[0] = 1'b0;
            act[1] = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i]) begin
                    if (off[i] == mw[i] * md[i] + 1) act[i] = 1'b0;
                    else off[i]++;
                end else if (get_start(i)) begin
                    act[i]  = 1'b1;
                    off[i]  = 1;
                    snap[i] = get_din(i);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_a", {27'b0, outs(0)}, {27'b0, expected(0)});
        chk("model_b", {27'b0, outs(1)}, {27'b0, expected(1)});
    end

    task automatic drive(input int i, input logic s, input logic [7:0] d);
        if (i == 0) begin start_a = s; din_a = d; end
        else        begin start_b = s; din_b = d; end
    endtask

    // Runs one frame on instance i and checks the reassembled word, done cycle and strobe placement.
    task automatic frame_lit(input string nm, input int i, input logic [7:0] data,
                             input logic [7:0] after, input logic [7:0] exp_word,
                             input int exp_done, input int exp_first_stb, input int exp_last_stb);
        logic [7:0] word = '0;
        logic [4:0] o;
        int k = 0, done_at = -1, first_stb = -1, last_stb = -1;
        @(negedge clk);
        drive(i, 1'b1, data);
        @(negedge clk);
        drive(i, 1'b0, after);
        for (int n = 1; n <= 60; n++) begin
            o = outs(i);
            if (o[3] && o[2]) begin
                if (k < 8) word[(ml[i] != 0) ? k : 7 - k] = o[4];
                k++;
                if (first_stb < 0) first_stb = n;
                last_stb = n;
            end
            if (o[0]) begin
                done_at = n;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_word"}, {24'b0, word}, {24'b0, exp_word});
        chk({nm, "_bits"}, k, 8);
        chk({nm, "_done_at"}, done_at, exp_done);
        chk({nm, "_first_stb"}, first_stb, exp_first_stb);
        chk({nm, "_last_stb"}, last_stb, exp_last_stb);
        @(negedge clk);
        chk({nm, "_idle_after"}, {27'b0, outs(i)}, 32'd0);
    endtask

    initial begin
        int nz;
        int dq[$];
        int bq[$];
        logic prev_busy;
        rst_n = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_a", {27'b0, outs(0)}, 32'd0);
        chk("reset_b", {27'b0, outs(1)}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        nz = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (outs(0) != 5'b0 || outs(1) != 5'b0) nz++;
        end
        chk("idle50_nonzero", nz, 0);

        frame_lit("a5",   0, 8'hA5, 8'hA5, 8'hA5, 9, 1, 8);
        frame_lit("c3",   1, 8'hC3, 8'hC3, 8'hC3, 25, 1, 22);
        frame_lit("snap", 0, 8'hFF, 8'h00, 8'hFF, 9, 1, 8);

        @(negedge clk);
        drive(0, 1'b1, 8'h5A);
        prev_busy = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done_a) dq.push_back(n);
            if (busy_a && !prev_busy) bq.push_back(n);
            prev_busy = busy_a;
        end
        drive(0, 1'b0, 8'h5A);
        chk("hold_ndone", dq.size(), 3);
        chk("hold_nframe", bq.size(), 3);
        for (int j = 0; j < 3; j++) begin
            chk("hold_done_cycle", (j < dq.size()) ? dq[j] : -1, 9 + 10 * j);
            chk("hold_frame_cycle", (j < bq.size()) ? bq[j] : -1, 1 + 10 * j);
        end
        repeat (12) @(negedge clk);

        drive(0, 1'b1, 8'hFF);
        @(negedge clk);
        drive(0, 1'b0, 8'hFF);
        repeat (3) @(negedge clk);
        chk("midframe_busy", {31'b0, busy_a}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_a", {27'b0, outs(0)}, 32'd0);
        chk("async_rst_b", {27'b0, outs(1)}, 32'd0);
        #1 rst_n = 1'b1;
        frame_lit("post_rst", 0, 8'h01, 8'h01, 8'h01, 9, 1, 8);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            drive(0, $urandom_range(0, 3) == 0, 8'($urandom));
            drive(1, $urandom_range(0, 5) == 0, 8'($urandom));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
